// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the bus sequencer blocks.
//   spi_tgt_state_t   : decode state of the SPI target responder
//   SPI_CMD_READ_BIT  : command bit that selects read (1) or write (0)
//   SPI_ADDR_W        : register address width
//   SPI_DATA_W        : register data width
//   spi_next_addr()   : address step with modulo-128 wrap, optional hold
package bus_sequencer_pkg;

  localparam int SPI_CMD_READ_BIT = 7;
  localparam int SPI_ADDR_W       = 7;
  localparam int SPI_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WDATA    = 3'd2,
    ST_RDATA    = 3'd3,
    ST_WAIT_END = 3'd4
  } spi_tgt_state_t;

  // Natural 7-bit overflow gives the 0x7F -> 0x00 wrap.
  function automatic logic [SPI_ADDR_W-1:0] spi_next_addr(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  inc
  );
    return inc ? addr + 1'b1 : addr;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with registered edge detection.
//   clk    : system clock
//   nrst   : asynchronous active-low reset
//   din    : asynchronous input pin
//   level  : synchronized level (STAGES clk after the pin)
//   rise   : one-clk pulse, STAGES+1 clk after a pin rising edge
//   fall   : one-clk pulse, STAGES+1 clk after a pin falling edge
// STAGES must be at least 2. RST_VAL is the level assumed during reset, so
// leaving reset at that level produces no edge pulse.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target_responder.sv
// SPI mode-0 target that turns a command byte plus data bytes into
// register-port reads and writes with an auto-incrementing address.
//   clk, nrst           : system clock, asynchronous active-low reset
//   spi_sclk_i          : SPI clock (async, oversampled on clk)
//   spi_ncs_i           : chip select, active low (async)
//   spi_mosi_i          : master data in, MSB first (async)
//   spi_miso_o          : read data out, MSB first, 0 when not shifting
//   reg_addr_o          : current register address
//   reg_wr_o/reg_wdata_o: one-clk write strobe and its data
//   reg_rd_o            : one-clk read strobe
//   reg_rdata_i         : read data, sampled the clk after reg_rd_o
//   frame_active_o      : high while a selected frame is being decoded
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | deselected, waiting for ncs to fall
// CMD         | shifting in the command byte
// WDATA       | shifting in write bytes, one write strobe per byte
// RDATA       | shifting out read bytes, one read strobe per byte
// WAIT_END    | came out of reset with ncs low; ignore sclk until ncs high
//
// Reset parks the FSM in WAIT_END and the ncs synchronizer at "selected".
// If ncs is really high the synchronized level resolves to IDLE within
// SYNC_STAGES clk; if it is low the target stays out of the frame it missed.
// WAIT_END does not count as decoding, so frame_active_o stays low there.
module spi_target_responder
  import bus_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ADDR_INC    = 1'b1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ncs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic [SPI_ADDR_W-1:0] reg_addr_o,
  output logic                  reg_wr_o,
  output logic [SPI_DATA_W-1:0] reg_wdata_o,
  output logic                  reg_rd_o,
  input  logic [SPI_DATA_W-1:0] reg_rdata_i,
  output logic                  frame_active_o
);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ncs_level;
  logic ncs_rise;
  logic ncs_fall;
  logic mosi;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .nrst  (nrst),
    .din   (spi_sclk_i),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
    .clk   (clk),
    .nrst  (nrst),
    .din   (spi_ncs_i),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .nrst  (nrst),
    .din   (spi_mosi_i),
    .level (mosi),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_tgt_state_t        state;
  logic [2:0]            bit_cnt;
  logic [6:0]            rx_sr;
  logic [SPI_DATA_W-1:0] tx_sr;
  logic                  load_tx;
  logic                  inc_pend;
  logic                  miso_q;

  // The byte being completed is {rx_sr, mosi}; the command's read flag is
  // therefore still in rx_sr[SPI_CMD_READ_BIT-1] on the 8th edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= ST_WAIT_END;
      bit_cnt        <= 3'd0;
      rx_sr          <= 7'd0;
      tx_sr          <= '0;
      load_tx        <= 1'b0;
      inc_pend       <= 1'b0;
      miso_q         <= 1'b0;
      reg_addr_o     <= '0;
      reg_wr_o       <= 1'b0;
      reg_wdata_o    <= '0;
      reg_rd_o       <= 1'b0;
      frame_active_o <= 1'b0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      load_tx  <= 1'b0;
      inc_pend <= 1'b0;

      if (load_tx) begin
        tx_sr <= reg_rdata_i;
      end
      // Write-side increment lands one clk after the strobe so the strobe
      // carries the address it was written to.
      if (inc_pend) begin
        reg_addr_o <= spi_next_addr(reg_addr_o, 1'b1);
      end

      case (state)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (ncs_fall) begin
            state          <= ST_CMD;
            bit_cnt        <= 3'd0;
            frame_active_o <= 1'b1;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_addr_o <= {rx_sr[5:0], mosi};
              if (rx_sr[SPI_CMD_READ_BIT-1]) begin
                reg_rd_o <= 1'b1;
                load_tx  <= 1'b1;
                state    <= ST_RDATA;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
        end

        ST_WDATA: begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_wdata_o <= {rx_sr, mosi};
              reg_wr_o    <= 1'b1;
              inc_pend    <= ADDR_INC;
            end
          end
        end

        ST_RDATA: begin
          // The master samples on the rise, so each fall presents the next
          // bit; the reload after the 8th rise beats the following fall.
          if (sclk_fall) begin
            miso_q <= tx_sr[SPI_DATA_W-1];
            tx_sr  <= {tx_sr[SPI_DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_addr_o <= spi_next_addr(reg_addr_o, ADDR_INC);
              reg_rd_o   <= 1'b1;
              load_tx    <= 1'b1;
            end
          end
        end

        ST_WAIT_END: begin
          miso_q <= 1'b0;
          if (ncs_level) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_WAIT_END;
        end
      endcase

      // Deselect wins over the state update but not over a byte that
      // completed in the same clk: its strobe above still goes out.
      if (ncs_rise) begin
        state          <= ST_IDLE;
        bit_cnt        <= 3'd0;
        miso_q         <= 1'b0;
        frame_active_o <= 1'b0;
      end
    end
  end

  assign spi_miso_o = miso_q;

endmodule
